// File: rtl/axi_arb2to1_if.sv
// AXI4 bus bundle (AR/R/AW/W/B) shared by the arbiter's master and slave sides.
// The master modport drives requests; the slave modport drives ready/response.
interface axi_arb2to1_if #(
    parameter int IDW   = 3,
    parameter int DWID  = 64,
    parameter int WSTRB = DWID / 8
);
    logic [IDW-1:0]   arid;
    logic [31:0]      araddr;
    logic [7:0]       arlen;
    logic [1:0]       arburst;
    logic             arvalid;
    logic             arready;
    logic [IDW-1:0]   rid;
    logic [DWID-1:0]  rdata;
    logic [1:0]       rresp;
    logic             rlast;
    logic             rvalid;
    logic             rready;
    logic [IDW-1:0]   awid;
    logic [31:0]      awaddr;
    logic [7:0]       awlen;
    logic [1:0]       awburst;
    logic             awvalid;
    logic             awready;
    logic [DWID-1:0]  wdata;
    logic [WSTRB-1:0] wstrb;
    logic             wlast;
    logic             wvalid;
    logic             wready;
    logic [IDW-1:0]   bid;
    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready;

    modport master (
        output arid, araddr, arlen, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready,
        output awid, awaddr, awlen, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready
    );
    modport slave (
        input  arid, araddr, arlen, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready,
        input  awid, awaddr, awlen, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready
    );
endinterface

// File: rtl/axi_arb2to1.sv
// Two-master to one-slave AXI4 arbiter: round-robin AR/AW, W steered in AW
// grant order, R/B routed back by the MSB of the slave-side ID.
module axi_arb2to1 #(
    parameter int IDWID     = 3,
    parameter int OFIFO_LOG = 2
) (
    input logic            clk,
    input logic            rst_n,
    axi_arb2to1_if.slave   m0,
    axi_arb2to1_if.slave   m1,
    axi_arb2to1_if.master  s
);
    localparam int OFIFO_DEP = 1 << OFIFO_LOG;

    typedef enum logic {IDLE, BUSY} arb_st_e;

    arb_st_e ar_st, ar_nst, aw_st, aw_nst;
    logic    ar_gnt, ar_gnt_nxt, ar_last, ar_last_nxt;
    logic    aw_gnt, aw_gnt_nxt, aw_last, aw_last_nxt;

    logic [OFIFO_DEP-1:0] of_mem;
    logic [OFIFO_LOG-1:0] of_wr, of_rd;
    logic [OFIFO_LOG:0]   of_cnt;
    logic                 of_full, of_empty, of_head, of_push, of_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ar_st   <= IDLE;
            ar_gnt  <= 1'b0;
            ar_last <= 1'b1;
            aw_st   <= IDLE;
            aw_gnt  <= 1'b0;
            aw_last <= 1'b1;
        end else begin
            ar_st   <= ar_nst;
            ar_gnt  <= ar_gnt_nxt;
            ar_last <= ar_last_nxt;
            aw_st   <= aw_nst;
            aw_gnt  <= aw_gnt_nxt;
            aw_last <= aw_last_nxt;
        end
    end

    // Grant is registered in IDLE, so the slave sees the request one cycle late.
    always_comb begin
        ar_nst      = ar_st;
        ar_gnt_nxt  = ar_gnt;
        ar_last_nxt = ar_last;
        s.arvalid   = (ar_st == BUSY) && (ar_gnt ? m1.arvalid : m0.arvalid);
        s.arid      = ar_gnt ? {1'b1, m1.arid} : {1'b0, m0.arid};
        s.araddr    = ar_gnt ? m1.araddr  : m0.araddr;
        s.arlen     = ar_gnt ? m1.arlen   : m0.arlen;
        s.arburst   = ar_gnt ? m1.arburst : m0.arburst;
        m0.arready  = (ar_st == BUSY) && !ar_gnt && s.arready;
        m1.arready  = (ar_st == BUSY) &&  ar_gnt && s.arready;
        case (ar_st)
            IDLE: if (m0.arvalid || m1.arvalid) begin
                ar_nst     = BUSY;
                ar_gnt_nxt = (m0.arvalid && m1.arvalid) ? !ar_last : m1.arvalid;
            end
            BUSY: if (s.arvalid && s.arready) begin
                ar_nst      = IDLE;
                ar_last_nxt = ar_gnt;
            end
            default: ar_nst = IDLE;
        endcase
    end

    // AW additionally stalls while the W-order FIFO has no room for the grant.
    always_comb begin
        aw_nst      = aw_st;
        aw_gnt_nxt  = aw_gnt;
        aw_last_nxt = aw_last;
        s.awvalid   = (aw_st == BUSY) && !of_full && (aw_gnt ? m1.awvalid : m0.awvalid);
        s.awid      = aw_gnt ? {1'b1, m1.awid} : {1'b0, m0.awid};
        s.awaddr    = aw_gnt ? m1.awaddr  : m0.awaddr;
        s.awlen     = aw_gnt ? m1.awlen   : m0.awlen;
        s.awburst   = aw_gnt ? m1.awburst : m0.awburst;
        m0.awready  = (aw_st == BUSY) && !aw_gnt && s.awready && !of_full;
        m1.awready  = (aw_st == BUSY) &&  aw_gnt && s.awready && !of_full;
        case (aw_st)
            IDLE: if (m0.awvalid || m1.awvalid) begin
                aw_nst     = BUSY;
                aw_gnt_nxt = (m0.awvalid && m1.awvalid) ? !aw_last : m1.awvalid;
            end
            BUSY: if (s.awvalid && s.awready) begin
                aw_nst      = IDLE;
                aw_last_nxt = aw_gnt;
            end
            default: aw_nst = IDLE;
        endcase
    end

    assign of_full  = (of_cnt == (OFIFO_LOG+1)'(OFIFO_DEP));
    assign of_empty = (of_cnt == '0);
    assign of_head  = of_mem[of_rd];
    assign of_push  = s.awvalid && s.awready;
    assign of_pop   = s.wvalid && s.wready && s.wlast;

    always_ff @(posedge clk) begin
        if (of_push) of_mem[of_wr] <= aw_gnt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            of_wr  <= '0;
            of_rd  <= '0;
            of_cnt <= '0;
        end else begin
            if (of_push) of_wr <= of_wr + 1'b1;
            if (of_pop)  of_rd <= of_rd + 1'b1;
            if (of_push && !of_pop)      of_cnt <= of_cnt + 1'b1;
            else if (of_pop && !of_push) of_cnt <= of_cnt - 1'b1;
        end
    end

    // W beats that arrive before their AW stay parked at the master.
    assign s.wvalid  = !of_empty && (of_head ? m1.wvalid : m0.wvalid);
    assign s.wdata   = of_head ? m1.wdata : m0.wdata;
    assign s.wstrb   = of_head ? m1.wstrb : m0.wstrb;
    assign s.wlast   = of_head ? m1.wlast : m0.wlast;
    assign m0.wready = !of_empty && !of_head && s.wready;
    assign m1.wready = !of_empty &&  of_head && s.wready;

    assign m0.rvalid = s.rvalid && !s.rid[IDWID];
    assign m1.rvalid = s.rvalid &&  s.rid[IDWID];
    assign m0.rid    = s.rid[IDWID-1:0];
    assign m1.rid    = s.rid[IDWID-1:0];
    assign m0.rdata  = s.rdata;
    assign m1.rdata  = s.rdata;
    assign m0.rresp  = s.rresp;
    assign m1.rresp  = s.rresp;
    assign m0.rlast  = s.rlast;
    assign m1.rlast  = s.rlast;
    assign s.rready  = s.rid[IDWID] ? m1.rready : m0.rready;

    assign m0.bvalid = s.bvalid && !s.bid[IDWID];
    assign m1.bvalid = s.bvalid &&  s.bid[IDWID];
    assign m0.bid    = s.bid[IDWID-1:0];
    assign m1.bid    = s.bid[IDWID-1:0];
    assign m0.bresp  = s.bresp;
    assign m1.bresp  = s.bresp;
    assign s.bready  = s.bid[IDWID] ? m1.bready : m0.bready;
endmodule

// File: tb/tb_axi_arb2to1.sv
// Bench for axi_arb2to1: directed master/slave vectors, a queue-based model
// checked every cycle, and literal expectations for the key scenarios.
module tb_axi_arb2to1;
    logic clk, rst_n;

    axi_arb2to1_if #(.IDW(3)) m0_if ();
    axi_arb2to1_if #(.IDW(3)) m1_if ();
    axi_arb2to1_if #(.IDW(4)) s_if ();

    axi_arb2to1 #(.IDWID(3), .OFIFO_LOG(2)) dut (
        .clk(clk), .rst_n(rst_n), .m0(m0_if), .m1(m1_if), .s(s_if)
    );

    // Master-side stimulus and observed outputs, indexable by master number.
    logic [2:0]  m_arid[2], m_awid[2], m_rid[2], m_bid[2];
    logic [31:0] m_araddr[2], m_awaddr[2];
    logic [7:0]  m_arlen[2], m_awlen[2], m_wstrb[2];
    logic [1:0]  m_arburst[2], m_awburst[2];
    logic [63:0] m_wdata[2], m_rdata[2];
    logic        m_arvalid[2], m_rready[2], m_awvalid[2], m_wlast[2], m_wvalid[2], m_bready[2];
    logic        m_arready[2], m_awready[2], m_wready[2], m_rvalid[2], m_rlast[2], m_bvalid[2];

    assign m0_if.arid = m_arid[0]; assign m0_if.araddr = m_araddr[0]; assign m0_if.arlen = m_arlen[0];
    assign m0_if.arburst = m_arburst[0]; assign m0_if.arvalid = m_arvalid[0]; assign m0_if.rready = m_rready[0];
    assign m0_if.awid = m_awid[0]; assign m0_if.awaddr = m_awaddr[0]; assign m0_if.awlen = m_awlen[0];
    assign m0_if.awburst = m_awburst[0]; assign m0_if.awvalid = m_awvalid[0]; assign m0_if.wdata = m_wdata[0];
    assign m0_if.wstrb = m_wstrb[0]; assign m0_if.wlast = m_wlast[0]; assign m0_if.wvalid = m_wvalid[0];
    assign m0_if.bready = m_bready[0];
    assign m1_if.arid = m_arid[1]; assign m1_if.araddr = m_araddr[1]; assign m1_if.arlen = m_arlen[1];
    assign m1_if.arburst = m_arburst[1]; assign m1_if.arvalid = m_arvalid[1]; assign m1_if.rready = m_rready[1];
    assign m1_if.awid = m_awid[1]; assign m1_if.awaddr = m_awaddr[1]; assign m1_if.awlen = m_awlen[1];
    assign m1_if.awburst = m_awburst[1]; assign m1_if.awvalid = m_awvalid[1]; assign m1_if.wdata = m_wdata[1];
    assign m1_if.wstrb = m_wstrb[1]; assign m1_if.wlast = m_wlast[1]; assign m1_if.wvalid = m_wvalid[1];
    assign m1_if.bready = m_bready[1];
    assign m_arready[0] = m0_if.arready; assign m_awready[0] = m0_if.awready; assign m_wready[0] = m0_if.wready;
    assign m_rvalid[0] = m0_if.rvalid; assign m_rid[0] = m0_if.rid; assign m_rdata[0] = m0_if.rdata;
    assign m_rlast[0] = m0_if.rlast; assign m_bvalid[0] = m0_if.bvalid; assign m_bid[0] = m0_if.bid;
    assign m_arready[1] = m1_if.arready; assign m_awready[1] = m1_if.awready; assign m_wready[1] = m1_if.wready;
    assign m_rvalid[1] = m1_if.rvalid; assign m_rid[1] = m1_if.rid; assign m_rdata[1] = m1_if.rdata;
    assign m_rlast[1] = m1_if.rlast; assign m_bvalid[1] = m1_if.bvalid; assign m_bid[1] = m1_if.bid;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: who owns each address channel (-1 = nobody), who was served last,
    // and the queue of masters whose write data the slave is waiting for.
    int ar_own, ar_prev, aw_own, aw_prev;
    int oq[$];
    bit chk_on = 1'b0;

    initial begin : mdl
        bit ar_hs, aw_hs, w_pop;
        int h;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                ar_own = -1; ar_prev = 1; aw_own = -1; aw_prev = 1;
                oq.delete();
                chk_on = 1'b1;
            end else begin
                ar_hs = (ar_own >= 0) ? (m_arvalid[ar_own] && s_if.arready) : 1'b0;
                aw_hs = (aw_own >= 0) ? (m_awvalid[aw_own] && s_if.awready && oq.size() < 4) : 1'b0;
                h     = (oq.size() > 0) ? oq[0] : 0;
                w_pop = (oq.size() > 0) && m_wvalid[h] && m_wlast[h] && s_if.wready;
                if (w_pop) void'(oq.pop_front());
                if (ar_own < 0) begin
                    if (m_arvalid[0] || m_arvalid[1])
                        ar_own = (m_arvalid[0] && m_arvalid[1]) ? 1 - ar_prev : (m_arvalid[1] ? 1 : 0);
                end else if (ar_hs) begin
                    ar_prev = ar_own; ar_own = -1;
                end
                if (aw_own < 0) begin
                    if (m_awvalid[0] || m_awvalid[1])
                        aw_own = (m_awvalid[0] && m_awvalid[1]) ? 1 - aw_prev : (m_awvalid[1] ? 1 : 0);
                end else if (aw_hs) begin
                    oq.push_back(aw_own);
                    aw_prev = aw_own; aw_own = -1;
                end
            end
        end
    end

    initial begin : cmp
        bit  e_v, full;
        int  h, sel;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                e_v = (ar_own >= 0) ? m_arvalid[ar_own] : 1'b0;
                chk("s_arvalid", s_if.arvalid, e_v);
                if (e_v) begin
                    chk("s_arid", s_if.arid, {ar_own == 1, m_arid[ar_own]});
                    chk("s_araddr", s_if.araddr, m_araddr[ar_own]);
                    chk("s_arlen", s_if.arlen, m_arlen[ar_own]);
                end
                for (int k = 0; k < 2; k++)
                    chk($sformatf("m%0d_arready", k), m_arready[k], ar_own == k && s_if.arready);
                full = oq.size() >= 4;
                e_v  = (aw_own >= 0) ? (m_awvalid[aw_own] && !full) : 1'b0;
                chk("s_awvalid", s_if.awvalid, e_v);
                if (e_v) begin
                    chk("s_awid", s_if.awid, {aw_own == 1, m_awid[aw_own]});
                    chk("s_awaddr", s_if.awaddr, m_awaddr[aw_own]);
                end
                for (int k = 0; k < 2; k++)
                    chk($sformatf("m%0d_awready", k), m_awready[k], aw_own == k && s_if.awready && !full);
                h   = (oq.size() > 0) ? oq[0] : -1;
                e_v = (h >= 0) ? m_wvalid[h] : 1'b0;
                chk("s_wvalid", s_if.wvalid, e_v);
                if (e_v) begin
                    chk("s_wdata", s_if.wdata, m_wdata[h]);
                    chk("s_wlast", s_if.wlast, m_wlast[h]);
                end
                for (int k = 0; k < 2; k++)
                    chk($sformatf("m%0d_wready", k), m_wready[k], h == k && s_if.wready);
                sel = s_if.rid[3] ? 1 : 0;
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("m%0d_rvalid", k), m_rvalid[k], s_if.rvalid && sel == k);
                    if (s_if.rvalid) begin
                        chk($sformatf("m%0d_rid", k), m_rid[k], s_if.rid[2:0]);
                        chk($sformatf("m%0d_rdata", k), m_rdata[k], s_if.rdata);
                        chk($sformatf("m%0d_rlast", k), m_rlast[k], s_if.rlast);
                    end
                end
                chk("s_rready", s_if.rready, m_rready[sel]);
                sel = s_if.bid[3] ? 1 : 0;
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("m%0d_bvalid", k), m_bvalid[k], s_if.bvalid && sel == k);
                    if (s_if.bvalid) chk($sformatf("m%0d_bid", k), m_bid[k], s_if.bid[2:0]);
                end
                chk("s_bready", s_if.bready, m_bready[sel]);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int acc, ng;
    logic [3:0] gr[4];

    initial begin : stim
        for (int k = 0; k < 2; k++) begin
            m_arid[k] = '0; m_araddr[k] = '0; m_arlen[k] = '0; m_arburst[k] = 2'd1; m_arvalid[k] = 1'b0;
            m_rready[k] = 1'b0; m_awid[k] = '0; m_awaddr[k] = '0; m_awlen[k] = '0; m_awburst[k] = 2'd1;
            m_awvalid[k] = 1'b0; m_wdata[k] = '0; m_wstrb[k] = 8'hFF; m_wlast[k] = 1'b0;
            m_wvalid[k] = 1'b0; m_bready[k] = 1'b0;
        end
        s_if.arready = 1'b0; s_if.rid = '0; s_if.rdata = '0; s_if.rresp = '0; s_if.rlast = 1'b0;
        s_if.rvalid = 1'b0; s_if.awready = 1'b0; s_if.wready = 1'b0; s_if.bid = '0;
        s_if.bresp = '0; s_if.bvalid = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_s_arvalid", s_if.arvalid, 0); chk("rst_s_awvalid", s_if.awvalid, 0);
        chk("rst_s_wvalid", s_if.wvalid, 0);   chk("rst_s_rready", s_if.rready, 0);
        chk("rst_m0_arready", m_arready[0], 0); chk("rst_m1_wready", m_wready[1], 0);
        rst_n = 1'b1;

        // Single read burst from m0.
        m_arvalid[0] = 1'b1; m_arid[0] = 3'd2; m_araddr[0] = 32'h40; m_arlen[0] = 8'd3;
        tick();
        chk("t1_arvalid", s_if.arvalid, 1); chk("t1_arid", s_if.arid, 4'h2); chk("t1_araddr", s_if.araddr, 32'h40);
        s_if.arready = 1'b1;
        tick();
        m_arvalid[0] = 1'b0; s_if.arready = 1'b0; m_rready[0] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            s_if.rvalid = 1'b1; s_if.rid = 4'h2; s_if.rdata = 64'h100 + 64'(b); s_if.rlast = (b == 3);
            #1;
            chk("t1_m0_rvalid", m_rvalid[0], 1); chk("t1_m0_rid", m_rid[0], 3'd2);
            chk("t1_m0_rlast", m_rlast[0], b == 3); chk("t1_m1_rvalid", m_rvalid[1], 0);
            tick();
        end
        s_if.rvalid = 1'b0; s_if.rlast = 1'b0; m_rready[0] = 1'b0;

        // AR tie from reset, both masters requesting continuously.
        do_reset();
        m_arvalid[0] = 1'b1; m_arid[0] = 3'd1; m_araddr[0] = 32'h100;
        m_arvalid[1] = 1'b1; m_arid[1] = 3'd5; m_araddr[1] = 32'h200;
        s_if.arready = 1'b1; ng = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (s_if.arvalid && ng < 4) begin gr[ng] = s_if.arid; ng++; end
        end
        chk("t2_ngrants", ng, 4);
        chk("t2_g0", gr[0], 4'h1); chk("t2_g1", gr[1], 4'hD); chk("t2_g2", gr[2], 4'h1); chk("t2_g3", gr[3], 4'hD);
        m_arvalid[0] = 1'b0; m_arvalid[1] = 1'b0; s_if.arready = 1'b0;
        tick();

        // W ordering: m1's 2-beat burst then m0's single beat, both W presented early.
        s_if.awready = 1'b1; s_if.wready = 1'b1;
        m_awvalid[1] = 1'b1; m_awid[1] = 3'd3; m_awaddr[1] = 32'h300; m_awlen[1] = 8'd1;
        m_wvalid[0] = 1'b1; m_wdata[0] = 64'hA0; m_wlast[0] = 1'b1;
        m_wvalid[1] = 1'b1; m_wdata[1] = 64'hB0; m_wlast[1] = 1'b0;
        tick();
        chk("t3_awid_m1", s_if.awid, 4'hB); chk("t3_wvalid_early", s_if.wvalid, 0); chk("t3_m0_wready_a", m_wready[0], 0);
        m_awvalid[0] = 1'b1; m_awid[0] = 3'd0; m_awaddr[0] = 32'h80; m_awlen[0] = 8'd0;
        tick();
        m_awvalid[1] = 1'b0;
        #1;
        chk("t3_wdata_b0", s_if.wdata, 64'hB0); chk("t3_m1_wready", m_wready[1], 1); chk("t3_m0_wready_b", m_wready[0], 0);
        tick();
        m_wdata[1] = 64'hB1; m_wlast[1] = 1'b1;
        #1;
        chk("t3_wdata_b1", s_if.wdata, 64'hB1); chk("t3_m0_wready_c", m_wready[0], 0); chk("t3_awid_m0", s_if.awid, 4'h0);
        tick();
        m_awvalid[0] = 1'b0; m_wvalid[1] = 1'b0; m_wlast[1] = 1'b0;
        #1;
        chk("t3_wdata_a0", s_if.wdata, 64'hA0); chk("t3_m0_wready_d", m_wready[0], 1); chk("t3_m1_wready_d", m_wready[1], 0);
        tick();
        m_wvalid[0] = 1'b0; m_wlast[0] = 1'b0;
        #1;
        chk("t3_w_done", s_if.wvalid, 0);

        // Order FIFO fills while the slave stalls W.
        s_if.wready = 1'b0; s_if.awready = 1'b1; acc = 0;
        m_awvalid[0] = 1'b1; m_awid[0] = 3'd1; m_awaddr[0] = 32'h400; m_awlen[0] = 8'd0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_if.awvalid) acc++;
        end
        chk("t4_accepted", acc, 4); chk("t4_stall_awvalid", s_if.awvalid, 0); chk("t4_stall_awready", m_awready[0], 0);
        s_if.wready = 1'b1; m_wvalid[0] = 1'b1; m_wlast[0] = 1'b1; m_wdata[0] = 64'hC0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_if.awvalid) begin acc++; break; end
        end
        tick();
        m_awvalid[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!s_if.wvalid) break;
            tick();
        end
        chk("t4_accepted_all", acc, 5); chk("t4_drained", s_if.wvalid, 0);
        m_wvalid[0] = 1'b0; m_wlast[0] = 1'b0; s_if.awready = 1'b0;
        tick();

        // B held by m1 backpressure.
        s_if.bvalid = 1'b1; s_if.bid = 4'hB; m_bready[0] = 1'b1; m_bready[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_m1_bvalid", m_bvalid[1], 1); chk("t5_m1_bid", m_bid[1], 3'd3);
            chk("t5_s_bready", s_if.bready, 0); chk("t5_m0_bvalid", m_bvalid[0], 0);
            tick();
        end
        m_bready[1] = 1'b1;
        #1;
        chk("t5_s_bready_rel", s_if.bready, 1);
        tick();
        s_if.bvalid = 1'b0; m_bready[0] = 1'b0; m_bready[1] = 1'b0;

        // Reset in the middle of a W burst.
        s_if.awready = 1'b1; s_if.wready = 1'b1;
        m_awvalid[0] = 1'b1; m_awid[0] = 3'd2; m_awaddr[0] = 32'h500; m_awlen[0] = 8'd1;
        m_wvalid[0] = 1'b1; m_wdata[0] = 64'hD0; m_wlast[0] = 1'b0;
        tick(); tick();
        m_awvalid[0] = 1'b0;
        #1;
        chk("t6_wvalid_pre", s_if.wvalid, 1);
        tick();
        do_reset();
        chk("t6_s_wvalid", s_if.wvalid, 0); chk("t6_m0_wready", m_wready[0], 0);
        chk("t6_s_awvalid", s_if.awvalid, 0); chk("t6_s_arvalid", s_if.arvalid, 0);
        chk("t6_m0_awready", m_awready[0], 0); chk("t6_s_rready", s_if.rready, 0); chk("t6_s_bready", s_if.bready, 0);
        m_arvalid[0] = 1'b1; m_arid[0] = 3'd6; m_arvalid[1] = 1'b1; m_arid[1] = 3'd7; s_if.arready = 1'b0;
        tick();
        chk("t6_tie_m0", s_if.arid, 4'h6);
        m_arvalid[0] = 1'b0; m_arvalid[1] = 1'b0; m_wvalid[0] = 1'b0;
        s_if.awready = 1'b0; s_if.wready = 1'b0;
        do_reset();
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
